// File: rtl/branch_predictor_pkg.sv
// Shared types for the bimodal branch predictor: 2-bit counter encodings and
// table geometry helpers.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    CntSnt = 2'b00,
    CntWnt = 2'b01,
    CntWt  = 2'b10,
    CntSt  = 2'b11
  } bht_cnt_e;

  // Saturating step of a 2-bit counter towards the observed outcome.
  function automatic bht_cnt_e bht_step(input bht_cnt_e cnt, input logic taken);
    bht_cnt_e res;
    res = cnt;
    if (taken && cnt != CntSt) begin
      res = bht_cnt_e'(cnt + 2'b01);
    end else if (!taken && cnt != CntSnt) begin
      res = bht_cnt_e'(cnt - 2'b01);
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_table.sv
// Bimodal history table: array of 2-bit saturating counters with one
// combinational read port and one synchronous update port.
module bht_table
  import branch_predictor_pkg::*;
#(
  parameter int unsigned Entries = 64,
  parameter int unsigned IdxW    = $clog2(Entries)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [IdxW-1:0] rd_idx_i,
  output bht_cnt_e        rd_cnt_o,
  input  logic            wr_en_i,
  input  logic [IdxW-1:0] wr_idx_i,
  input  logic            wr_taken_i
);

  bht_cnt_e cnt_q [Entries];

  // No bypass: a same-cycle update is only visible after the edge.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Entries; i++) begin
        cnt_q[i] <= CntWnt;
      end
    end else if (wr_en_i) begin
      cnt_q[wr_idx_i] <= bht_step(cnt_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage bimodal predictor and execute-stage resolver issuing a one-cycle
// registered redirect/flush on mispredict, plus wrapping performance counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_id_valid,
  input  logic        i_id_is_branch,
  input  logic [31:0] i_id_pc,
  input  logic [31:0] i_id_imm,
  output logic        o_id_pred_taken,
  output logic [31:0] o_id_target,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic [31:0] i_ex_pc,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic        i_ex_taken,
  input  logic        i_stall,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic [31:0] o_branch_count,
  output logic [31:0] o_mispredict_count
);

  localparam int unsigned IdxW = $clog2(BHT_ENTRIES);

  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;
  logic        resolve, mispredict;
  bht_cnt_e    id_cnt;

  bht_table #(
    .Entries (BHT_ENTRIES),
    .IdxW    (IdxW)
  ) u_bht (
    .clk_i      (i_clk),
    .rst_ni     (i_rst_n),
    .rd_idx_i   (i_id_pc[IdxW+1:2]),
    .rd_cnt_o   (id_cnt),
    .wr_en_i    (resolve),
    .wr_idx_i   (i_ex_pc[IdxW+1:2]),
    .wr_taken_i (i_ex_taken)
  );

  assign o_id_pred_taken = i_id_valid & i_id_is_branch & id_cnt[1];
  assign o_id_target     = i_id_pc + i_id_imm;

  // The execute slot is wrong-path while a redirect is being issued.
  assign resolve    = i_ex_valid & i_ex_is_branch & ~i_stall & ~redirect_q;
  assign mispredict = resolve & (i_ex_taken != i_ex_pred_taken);

  always_comb begin
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve) begin
      branch_cnt_d = branch_cnt_q + 32'd1;
    end
    if (mispredict) begin
      redirect_pc_d = i_ex_taken ? i_ex_target : i_ex_pc + 32'd4;
      mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_redirect         = redirect_q;
  assign o_flush            = redirect_q;
  assign o_redirect_pc      = redirect_pc_q;
  assign o_branch_count     = branch_cnt_q;
  assign o_mispredict_count = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_is_branch;
  logic [31:0] id_pc, id_imm;
  logic        id_pred_taken;
  logic [31:0] id_target;
  logic        ex_valid, ex_is_branch, ex_pred_taken, ex_taken, stall;
  logic [31:0] ex_pc, ex_target;
  logic        redirect, flush;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(
    .BHT_ENTRIES (64)
  ) dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_id_valid         (id_valid),
    .i_id_is_branch     (id_is_branch),
    .i_id_pc            (id_pc),
    .i_id_imm           (id_imm),
    .o_id_pred_taken    (id_pred_taken),
    .o_id_target        (id_target),
    .i_ex_valid         (ex_valid),
    .i_ex_is_branch     (ex_is_branch),
    .i_ex_pc            (ex_pc),
    .i_ex_target        (ex_target),
    .i_ex_pred_taken    (ex_pred_taken),
    .i_ex_taken         (ex_taken),
    .i_stall            (stall),
    .o_redirect         (redirect),
    .o_redirect_pc      (redirect_pc),
    .o_flush            (flush),
    .o_branch_count     (branch_count),
    .o_mispredict_count (mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_redirect(input string tag, input logic exp_r, input logic [31:0] exp_pc);
    check({tag, "_redirect"}, {31'd0, redirect}, {31'd0, exp_r});
    check({tag, "_flush"}, {31'd0, flush}, {31'd0, exp_r});
    check({tag, "_redirect_pc"}, redirect_pc, exp_pc);
  endtask

  task automatic check_counts(input string tag, input int exp_b, input int exp_m);
    check({tag, "_branch_count"}, branch_count, exp_b);
    check({tag, "_mispredict_count"}, mispredict_count, exp_m);
  endtask

  task automatic set_ex(input logic v, input logic [31:0] pc, input logic [31:0] tgt,
                        input logic pred, input logic tkn);
    ex_valid      = v;
    ex_is_branch  = v;
    ex_pc         = pc;
    ex_target     = tgt;
    ex_pred_taken = pred;
    ex_taken      = tkn;
  endtask

  initial begin
    rst_n        = 1'b0;
    id_valid     = 1'b1;
    id_is_branch = 1'b1;
    id_pc        = 32'h100;
    id_imm       = 32'hFFFF_FFF0;
    stall        = 1'b0;
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #12;
    check_redirect("reset", 1'b0, 32'h0);
    check_counts("reset", 0, 0);
    check("reset_pred", {31'd0, id_pred_taken}, 32'd0);
    check("reset_target", id_target, 32'h0000_00F0);
    rst_n = 1'b1;
    step();

    // Three taken resolutions at 0x100, each mispredicted (pred 0).
    set_ex(1'b1, 32'h100, 32'h80, 1'b0, 1'b1);
    step();
    check_redirect("res1", 1'b1, 32'h80);
    check_counts("res1", 1, 1);
    check("res1_pred", {31'd0, id_pred_taken}, 32'd1);
    // Execute still holds a branch during the redirect cycle: wrong-path.
    step();
    check_redirect("wrongpath", 1'b0, 32'h80);
    check_counts("wrongpath", 1, 1);
    step();
    check_redirect("res2", 1'b1, 32'h80);
    check_counts("res2", 2, 2);
    step();
    check_counts("gap2", 2, 2);
    step();
    check_redirect("res3", 1'b1, 32'h80);
    check_counts("res3", 3, 3);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_redirect("post3", 1'b0, 32'h80);
    check("sat_pred_st", {31'd0, id_pred_taken}, 32'd1);
    id_valid = 1'b0;
    #1;
    check("pred_id_invalid", {31'd0, id_pred_taken}, 32'd0);
    id_valid = 1'b1;

    // Correctly predicted not-taken steps: ST -> WT -> WNT.
    set_ex(1'b1, 32'h100, 32'h80, 1'b0, 1'b0);
    step();
    check("dec1_pred", {31'd0, id_pred_taken}, 32'd1);
    check_counts("dec1", 4, 3);
    check("dec1_redirect", {31'd0, redirect}, 32'd0);
    step();
    check("dec2_pred", {31'd0, id_pred_taken}, 32'd0);
    check_counts("dec2", 5, 3);

    // Not-taken branch at 0x200 predicted taken.
    set_ex(1'b1, 32'h200, 32'h300, 1'b1, 1'b0);
    step();
    check_redirect("nt200", 1'b1, 32'h204);
    check_counts("nt200", 6, 4);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_redirect("nt200_end", 1'b0, 32'h204);

    // Stall for three cycles, then resolve once.
    set_ex(1'b1, 32'h300, 32'h400, 1'b1, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_counts("stall", 6, 4);
    end
    stall = 1'b0;
    step();
    check_counts("unstall", 7, 4);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    check_counts("unstall_once", 7, 4);
    check("unstall_redirect", {31'd0, redirect}, 32'd0);

    // Decode and execute at index 5 together: no bypass.
    id_pc = 32'h14;
    set_ex(1'b1, 32'h14, 32'h40, 1'b1, 1'b1);
    #1;
    check("idx5_same_cycle", {31'd0, id_pred_taken}, 32'd0);
    step();
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    check("idx5_next_cycle", {31'd0, id_pred_taken}, 32'd1);
    check_counts("idx5", 8, 4);

    // Reset during a redirect pulse cuts it and it does not return.
    set_ex(1'b1, 32'h400, 32'h500, 1'b1, 1'b0);
    step();
    check_redirect("pre_rst", 1'b1, 32'h404);
    set_ex(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_redirect("mid_rst", 1'b0, 32'h0);
    check_counts("mid_rst", 0, 0);
    check("mid_rst_pred", {31'd0, id_pred_taken}, 32'd0);
    rst_n = 1'b1;
    step();
    check_redirect("post_rst", 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
